// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame/timing constants.
package uart_pkg;

    // 100 MHz / 115200 baud, matching the transmitter on RS232_Uart_TX.
    localparam int unsigned ClksPerBitDefault = 868;

    // Data bits per 8N1 frame.
    localparam int unsigned FrameBits = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver. A push while full
// with no pop in the same cycle is dropped and flagged on 'drop'.
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned Width      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

    logic [Width-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             pop_en;
    logic             push_en;

    // Full/empty from the extra wrap bit; only real pops can make room.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        pop_en   = pop && !empty;
        push_en  = push && (!full || pop_en);
        drop     = push && full && !pop_en;
        wr_ptr_d = push_en ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + PtrOne : rd_ptr_q;
        pop_data = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the head is gated by empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a small
// receive FIFO with sticky overrun and one-cycle framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RS232_Uart_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    input  logic       OVR_CLR
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LastBit = 3'(FrameBits - 1);

    logic            rx_meta_q;
    logic            rxs_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q;
    logic            push;
    logic            cnt_expired;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_drop;

    // Synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RS232_Uart_RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // FSM, bit counter, shift register and error pulse state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: sample at counter expiry, reload a full bit each sample.
    always_comb begin
        state_d     = state_q;
        cnt_expired = (cnt_q == '0);
        cnt_d       = cnt_q - 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = CntHalf;
                end
            end
            StStart: begin
                if (cnt_expired) begin
                    if (!rxs_q) begin
                        state_d   = StData;
                        cnt_d     = CntFull;
                        bit_idx_d = '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as a glitch.
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_expired) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = CntFull;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_expired) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Held-low line must return high before another start is seen.
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun_q <= 1'b0;
        end else if (fifo_drop) begin
            overrun_q <= 1'b1;
        end else if (OVR_CLR) begin
            overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .Width      (8)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (shift_q),
        .pop       (RX_READY),
        .pop_data  (RX_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // Output mapping.
    always_comb begin
        RX_VALID  = !fifo_empty;
        FRAME_ERR = frame_err_q;
        OVERRUN   = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned Cpb = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RS232_Uart_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       OVR_CLR = 1'b0;

    int tests = 0;
    int fails = 0;
    int fe_count = 0;

    uart_rx #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RS232_Uart_RX (RS232_Uart_RX),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_READY      (RX_READY),
        .FRAME_ERR     (FRAME_ERR),
        .OVERRUN       (OVERRUN),
        .OVR_CLR       (OVR_CLR)
    );

    always #5 CLK = ~CLK;

    // Count cycles with FRAME_ERR high, sampled away from the active edge.
    always @(negedge CLK) begin
        if (FRAME_ERR) fe_count = fe_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive one 8N1 frame starting at the current negedge; stop level selectable.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
        RS232_Uart_RX = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < 8; i++) begin
            RS232_Uart_RX = b[i];
            wait_cycles(Cpb);
        end
        RS232_Uart_RX = stop_lvl;
        wait_cycles(stop_len);
        RS232_Uart_RX = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, RX_VALID}, 32'd1);
        check({tag, "_data"}, {24'd0, RX_DATA}, {24'd0, exp});
        RX_READY = 1'b1;
        wait_cycles(1);
        RX_READY = 1'b0;
    endtask

    int         lat;
    int         fe0;
    logic [7:0] got[$];

    initial begin
        wait_cycles(3);
        RST = 1'b0;
        wait_cycles(2);

        // Reset state
        check("rst_valid", {31'd0, RX_VALID}, 32'd0);
        check("rst_data", {24'd0, RX_DATA}, 32'd0);
        check("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
        check("rst_ovr", {31'd0, OVERRUN}, 32'd0);

        // Single frame 0xA5, consumer idle; RX_VALID expected ~155 cycles after start
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, Cpb);
            begin
                for (int k = 1; k <= 300; k++) begin
                    @(negedge CLK);
                    if (RX_VALID && lat < 0) lat = k;
                end
            end
        join
        check("a5_latency_ok", {31'd0, (lat >= 150 && lat <= 160)}, 32'd1);
        check("a5_data", {24'd0, RX_DATA}, 32'hA5);
        check("a5_no_ferr", fe_count, 32'd0);
        pop_check("a5_pop", 8'hA5);
        check("a5_empty", {31'd0, RX_VALID}, 32'd0);

        // Back-to-back 0x55, 0x0F with consumer always ready
        RX_READY = 1'b1;
        fork
            begin
                send_frame(8'h55, 1'b1, Cpb);
                send_frame(8'h0F, 1'b1, Cpb);
            end
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge CLK);
                    if (RX_VALID && RX_READY) got.push_back(RX_DATA);
                end
            end
        join
        RX_READY = 1'b0;
        check("b2b_count", got.size(), 32'd2);
        check("b2b_first", {24'd0, (got.size() > 0) ? got[0] : 8'hxx}, 32'h55);
        check("b2b_second", {24'd0, (got.size() > 1) ? got[1] : 8'hxx}, 32'h0F);
        check("b2b_empty", {31'd0, RX_VALID}, 32'd0);

        // 4-cycle low glitch on an idle line
        RS232_Uart_RX = 1'b0;
        wait_cycles(4);
        RS232_Uart_RX = 1'b1;
        wait_cycles(40);
        check("glitch_idle", {29'd0, dut.state_q}, {29'd0, StIdle});
        check("glitch_valid", {31'd0, RX_VALID}, 32'd0);
        check("glitch_ferr", fe_count, 32'd0);

        // 0x3C with low stop bit, line held low 40 further cycles
        fe0 = fe_count;
        send_frame(8'h3C, 1'b0, Cpb + 40);
        check("ferr_pulse_held", fe_count - fe0, 32'd1);
        check("ferr_valid", {31'd0, RX_VALID}, 32'd0);
        wait_cycles(40);
        check("ferr_pulse_after", fe_count - fe0, 32'd1);
        check("ferr_idle", {29'd0, dut.state_q}, {29'd0, StIdle});
        check("ferr_valid_after", {31'd0, RX_VALID}, 32'd0);

        // Five frames into a 4-deep FIFO with no consumer
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, Cpb);
        check("ovr_not_yet", {31'd0, OVERRUN}, 32'd0);
        send_frame(8'h05, 1'b1, Cpb);
        check("ovr_set", {31'd0, OVERRUN}, 32'd1);
        pop_check("ovr_pop1", 8'h01);
        pop_check("ovr_pop2", 8'h02);
        pop_check("ovr_pop3", 8'h03);
        pop_check("ovr_pop4", 8'h04);
        check("ovr_drained", {31'd0, RX_VALID}, 32'd0);
        check("ovr_sticky", {31'd0, OVERRUN}, 32'd1);
        OVR_CLR = 1'b1;
        wait_cycles(1);
        OVR_CLR = 1'b0;
        check("ovr_cleared", {31'd0, OVERRUN}, 32'd0);

        // Reset during bit 3 of 0xFF with a byte already buffered
        send_frame(8'h42, 1'b1, Cpb);
        check("rst2_pre_valid", {31'd0, RX_VALID}, 32'd1);
        fork
            send_frame(8'hFF, 1'b1, Cpb);
            begin
                wait_cycles(Cpb * 4 + 8);
                RST = 1'b1;
                wait_cycles(1);
                RST = 1'b0;
                check("rst2_valid", {31'd0, RX_VALID}, 32'd0);
                check("rst2_data", {24'd0, RX_DATA}, 32'd0);
                check("rst2_ferr", {31'd0, FRAME_ERR}, 32'd0);
                check("rst2_ovr", {31'd0, OVERRUN}, 32'd0);
            end
        join
        fe0 = fe_count;
        wait_cycles(20);
        check("rst2_no_frame", {31'd0, RX_VALID}, 32'd0);
        send_frame(8'h81, 1'b1, Cpb);
        check("rst2_no_ferr", fe_count - fe0, 32'd0);
        pop_check("rst2_pop81", 8'h81);
        check("rst2_empty", {31'd0, RX_VALID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
